alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the 32-bit ALU.
- Captures decoded operands and control fields each cycle and derives the 4-bit ALUcontrol code from ALUOp/funct.
- Resolves EX/MEM and MEM/WB forwarding to drive Op1/Op2.
- Detects load-use hazards and inserts bubbles, with stall and flush handshakes toward the front end and hazard unit.

Parameters:
- XLEN, 32, datapath width of operands and results.
- REGW, 5, register-address width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  ID stage presents a valid instruction
- id_rs1_addr, id_rs2_addr  input  REGW  source register addresses
- id_rd_addr  input  REGW  destination register
- id_rs1_data, id_rs2_data  input  XLEN  register-file read data
- id_imm  input  XLEN  sign-extended immediate
- id_ALUOp  input  2  00 = add, 01 = sub, 10 = R-type, 11 = I-type arithmetic
- id_funct3  input  3  instruction funct3
- id_funct7b5  input  1  instruction bit 30
- id_ALUSrc  input  1  1 selects immediate for Op2
- id_RegWrite, id_MemRead  input  1  control bits
- stall  input  1  external freeze, e.g. from memory
- flush  input  1  kill the instruction entering EX, e.g. on a taken branch
- exmem_RegWrite  input  1  EX/MEM writeback enable
- exmem_rd  input  REGW  EX/MEM destination register
- exmem_result  input  XLEN  EX/MEM result
- memwb_RegWrite  input  1  MEM/WB writeback enable
- memwb_rd  input  REGW  MEM/WB destination register
- memwb_result  input  XLEN  MEM/WB result
- Op1, Op2  output  XLEN  ALU operands, forwarded
- ALUcontrol  output  4  registered ALU opcode
- ex_valid, ex_RegWrite, ex_MemRead  output  1  registered control bits
- ex_rd  output  REGW  registered destination register
- ex_store_data  output  XLEN  forwarded rs2 value for stores
- illegal_op  output  1  registered; unsupported funct3 was captured
- hazard_stall  output  1  combinational; upstream must hold PC and IF/ID

Behaviour:
- Reset, asynchronous on rst_n low:
  - All stage registers clear to 0, so ex_valid=0, ex_RegWrite=0, ex_MemRead=0, ex_rd=0, ALUcontrol=4'b0000, illegal_op=0.
  - Op1 and Op2 then evaluate to 0.
  - Reset mid-instruction discards that instruction.
- hazard_stall = ex_valid & ex_MemRead & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1_addr) | (!id_ALUSrc & ex_rd == id_rs2_addr)).
- Register update priority at each rising edge:
  1. flush: capture a bubble (valid, RegWrite, MemRead, illegal_op all 0; other fields don't-care). Flush wins over stall.
  2. stall: hold every register.
  3. hazard_stall: capture a bubble.
  4. Otherwise capture the ID fields, with valid = id_valid.
- Latency: one cycle from ID inputs to the registered EX fields.
- ALUcontrol decode, computed at capture:
  - ALUOp 00 -> 0010 (add).
  - ALUOp 01 -> 0110 (sub).
  - ALUOp 10 (R-type), by funct3:
    - 000 -> 0110 if funct7b5 else 0010.
    - 111 -> 0000 (and).
    - 110 -> 0001 (or).
    - 010 -> 0111 (slt).
    - 100 -> 1100 (nor, team extension).
  - ALUOp 11 (I-type): same funct3 map as ALUOp 10, but funct7b5 is ignored, so 000 -> 0010.
  - Any other funct3 -> 0010 with illegal_op=1.
- Forwarding, combinational, applied separately to the rs1 and rs2 paths:
  - If exmem_RegWrite & exmem_rd != 0 & exmem_rd == rs, select exmem_result.
  - Else if memwb_RegWrite & memwb_rd != 0 & memwb_rd == rs, select memwb_result.
  - Else select the registered data.
  - x0 is never forwarded.
- Operand outputs:
  - Op1 = forwarded rs1.
  - Op2 = registered imm if ALUSrc, else forwarded rs2.
  - ex_store_data = forwarded rs2, regardless of ALUSrc.
- Bubbles are not masked on the data path: downstream gates all effects with ex_valid.

Decomposition:
- Shared package alu_pkg holds:
  - ALU opcode constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_NOR=4'b1100.
  - ALUOp encodings.
  - funct3 constants.
- One sub-module, alu_ctrl_decode: the combinational decode of ALUOp/funct3/funct7b5 to ALUcontrol and illegal.
- Forwarding muxes and hazard detection stay inline.

Test Plan:
- R-type sub: ALUOp=10, funct3=000, funct7b5=1, rs1_data=10, rs2_data=3 -> next cycle ALUcontrol=0110, Op1=10, Op2=3.
- I-type add: ALUOp=11, funct3=000, funct7b5=1, ALUSrc=1, imm=-4 -> ALUcontrol=0010, Op2=32'hFFFFFFFC.
- Forwarding: captured rs1=5, rs1_data=1; exmem_rd=5 with result 7 and memwb_rd=5 with result 9 -> Op1=7; drop exmem_RegWrite -> Op1=9; rs1=0 with exmem_rd=0 -> Op1=captured data.
- Load-use: EX holds MemRead with ex_rd=3, ID rs2=3, ALUSrc=0 -> hazard_stall=1 and next cycle ex_valid=0; with ALUSrc=1 -> hazard_stall=0.
- Stall and flush:
  - stall=1 for 3 cycles -> all registered outputs unchanged.
  - stall=1 and flush=1 together -> bubble captured (ex_valid=0, ex_RegWrite=0).
- Reset and illegal op:
  - Assert rst_n=0 mid-stream, between clock edges -> outputs clear immediately (ALUcontrol=0000, ex_valid=0).
  - funct3=001 with ALUOp=10 -> ALUcontrol=0010 and illegal_op=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcode, ALUOp and funct3 encodings for the issue stage and its decoder.
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_RTYPE = 2'b10,
      ALUOP_ITYPE = 2'b11
   } aluop_e;

   localparam logic [2:0] F3_ADDSUB = 3'b000;
   localparam logic [2:0] F3_SLT    = 3'b010;
   localparam logic [2:0] F3_NOR    = 3'b100;
   localparam logic [2:0] F3_OR     = 3'b110;
   localparam logic [2:0] F3_AND    = 3'b111;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct3/funct7b5 to ALUcontrol decode with unsupported-funct3 flag.
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output logic [3:0] alucontrol,
   output logic       illegal
);

   always_comb begin
      alucontrol = ALU_ADD;
      illegal    = 1'b0;
      case (aluop_e'(aluop))
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         default: begin
            case (funct3)
               // I-type shares the map but bit 30 belongs to the immediate there
               F3_ADDSUB: alucontrol = (aluop_e'(aluop) == ALUOP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
               F3_AND:    alucontrol = ALU_AND;
               F3_OR:     alucontrol = ALU_OR;
               F3_SLT:    alucontrol = ALU_SLT;
               F3_NOR:    alucontrol = ALU_NOR;
               default:   illegal    = 1'b1;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX stage feeding the ALU: decode capture, EX/MEM and MEM/WB forwarding, load-use bubbles.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [REGW-1:0] id_rs1_addr,
   input  logic [REGW-1:0] id_rs2_addr,
   input  logic [REGW-1:0] id_rd_addr,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [1:0]      id_ALUOp,
   input  logic [2:0]      id_funct3,
   input  logic            id_funct7b5,
   input  logic            id_ALUSrc,
   input  logic            id_RegWrite,
   input  logic            id_MemRead,
   input  logic            stall,
   input  logic            flush,
   input  logic            exmem_RegWrite,
   input  logic [REGW-1:0] exmem_rd,
   input  logic [XLEN-1:0] exmem_result,
   input  logic            memwb_RegWrite,
   input  logic [REGW-1:0] memwb_rd,
   input  logic [XLEN-1:0] memwb_result,
   output logic [XLEN-1:0] Op1,
   output logic [XLEN-1:0] Op2,
   output logic [3:0]      ALUcontrol,
   output logic            ex_valid,
   output logic            ex_RegWrite,
   output logic            ex_MemRead,
   output logic [REGW-1:0] ex_rd,
   output logic [XLEN-1:0] ex_store_data,
   output logic            illegal_op,
   output logic            hazard_stall
);

   logic [REGW-1:0] rs1_q, rs2_q;
   logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q;
   logic            alusrc_q;
   logic [3:0]      dec_ctrl;
   logic            dec_illegal;
   logic            advance, bubble;
   logic [XLEN-1:0] fwd1, fwd2;

   alu_ctrl_decode u_decode (
      .aluop      (id_ALUOp),
      .funct3     (id_funct3),
      .funct7b5   (id_funct7b5),
      .alucontrol (dec_ctrl),
      .illegal    (dec_illegal)
   );

   assign hazard_stall = ex_valid & ex_MemRead & (ex_rd != '0) & id_valid &
                         ((ex_rd == id_rs1_addr) | (~id_ALUSrc & (ex_rd == id_rs2_addr)));

   // Bubbles still load the datapath fields; only the control bits are zeroed.
   assign advance = flush | ~stall;
   assign bubble  = flush | hazard_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid    <= 1'b0;
         ex_RegWrite <= 1'b0;
         ex_MemRead  <= 1'b0;
         illegal_op  <= 1'b0;
         ex_rd       <= '0;
         ALUcontrol  <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         alusrc_q    <= 1'b0;
      end else if (advance) begin
         ex_valid    <= id_valid & ~bubble;
         ex_RegWrite <= id_RegWrite & ~bubble;
         ex_MemRead  <= id_MemRead & ~bubble;
         illegal_op  <= dec_illegal & ~bubble;
         ex_rd       <= id_rd_addr;
         ALUcontrol  <= dec_ctrl;
         rs1_q       <= id_rs1_addr;
         rs2_q       <= id_rs2_addr;
         rs1_data_q  <= id_rs1_data;
         rs2_data_q  <= id_rs2_data;
         imm_q       <= id_imm;
         alusrc_q    <= id_ALUSrc;
      end
   end

   always_comb begin
      fwd1 = rs1_data_q;
      if (exmem_RegWrite && exmem_rd != '0 && exmem_rd == rs1_q)
         fwd1 = exmem_result;
      else if (memwb_RegWrite && memwb_rd != '0 && memwb_rd == rs1_q)
         fwd1 = memwb_result;
   end

   always_comb begin
      fwd2 = rs2_data_q;
      if (exmem_RegWrite && exmem_rd != '0 && exmem_rd == rs2_q)
         fwd2 = exmem_result;
      else if (memwb_RegWrite && memwb_rd != '0 && memwb_rd == rs2_q)
         fwd2 = memwb_result;
   end

   assign Op1           = fwd1;
   assign Op2           = alusrc_q ? imm_q : fwd2;
   assign ex_store_data = fwd2;

endmodule
